// File: rtl/piradip_leading_zero_count.sv
// piradip_leading_zero_count
// AXI-stream normalisation front end. Each input word is passed through
// unchanged, prefixed with its leading-zero count (or, in signed mode, its
// redundant-sign-bit count). Output packing is {count, word}, so the result
// feeds piradip_left_shift directly.
//
// The count is built by a binary tree. Each node holds the full count for
// its span of bits. The MSB of a node count doubles as the node's
// "all zero" flag, because a node is all zero exactly when its count equals
// its span. With PIPELINE=1, the raw word is registered first and then every
// tree level is registered, giving L+1 stages. With PIPELINE=0, the tree is
// combinational from the input and only the final count is registered.
//
// Flow control is bubble-collapsing: a stage loads when it is empty or when
// its successor is loading. Downstream stalls therefore fill every empty
// stage before input ready falls.
module piradip_leading_zero_count #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  PIPELINE    = 1,
    parameter int  SIGNED      = 0,
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [DATA_WIDTH-1:0]             data_in_tdata,
    input  logic                              data_in_tvalid,
    output logic                              data_in_tready,
    input  logic                              data_in_tlast,
    output logic [SHIFT_WIDTH+DATA_WIDTH-1:0] data_out_tdata,
    output logic                              data_out_tvalid,
    input  logic                              data_out_tready,
    output logic                              data_out_tlast
);

    localparam int L  = $clog2(DATA_WIDTH);
    localparam int NS = (PIPELINE != 0) ? L + 1 : 1;

    // Bit i of the result marks a sign change between bit i and bit i-1.
    // Bit 0 is forced high, so the count can never exceed DATA_WIDTH-1.
    // The leading-zero count of this vector is the redundant-sign-bit count.
    function automatic logic [DATA_WIDTH-1:0] sign_flags(input logic [DATA_WIDTH-1:0] w);
        sign_flags = {w[DATA_WIDTH-1:1] ^ w[DATA_WIDTH-2:0], 1'b1};
    endfunction

    logic [NS-1:0]         valid_r;
    logic [NS-1:0]         last_r;
    logic [DATA_WIDTH-1:0] word_r [NS];
    logic [NS-1:0]         load_s;
    logic [NS-1:0]         in_valid_s;
    logic                  rst_done_r;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] tree_src_s;
    logic [DATA_WIDTH-1:0] tree_in_s;

    // Backward load-enable chain: a stage loads when it is empty or when its
    // successor loads. The last stage loads when the sink can take data.
    always_comb begin
        logic ld_v;
        load_s       = '0;
        ld_v         = ~valid_r[NS-1] | data_out_tready;
        load_s[NS-1] = ld_v;
        for (int k = NS - 2; k >= 0; k--) begin
            ld_v      = ~valid_r[k] | ld_v;
            load_s[k] = ld_v;
        end
    end

    // Input ready stays low until the first clock after reset release.
    assign data_in_tready = load_s[0] & rst_done_r;
    assign accept_s       = data_in_tvalid & data_in_tready;

    // Valid bit offered to each stage by its predecessor.
    always_comb begin
        in_valid_s    = '0;
        in_valid_s[0] = accept_s;
        for (int k = 1; k < NS; k++) begin
            in_valid_s[k] = valid_r[k-1];
        end
    end

    // Marks the first clock edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // Stage valid bits plus the word and tlast carried alongside the tree.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= '0;
            last_r  <= '0;
            for (int k = 0; k < NS; k++) begin
                word_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= in_valid_s[k];
                end
            end
            if (load_s[0] && in_valid_s[0]) begin
                word_r[0] <= data_in_tdata;
                last_r[0] <= data_in_tlast;
            end
            for (int k = 1; k < NS; k++) begin
                if (load_s[k] && in_valid_s[k]) begin
                    word_r[k] <= word_r[k-1];
                    last_r[k] <= last_r[k-1];
                end
            end
        end
    end

    // The pipelined tree starts from the registered word; the combinational
    // tree works straight from the input bus.
    assign tree_src_s = (PIPELINE != 0) ? word_r[0] : data_in_tdata;
    assign tree_in_s  = (SIGNED != 0) ? sign_flags(tree_src_s) : tree_src_s;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NN  = DATA_WIDTH >> (k + 1);  // nodes at this level
        localparam int CW  = k + 2;                  // count width per node
        localparam bit REG = (PIPELINE != 0) || (k == L - 1);
        localparam int STG = (PIPELINE != 0) ? k + 1 : 0;

        logic [NN*CW-1:0] comb_s;
        logic [NN*CW-1:0] out_s;

        if (k == 0) begin : g_leaf
            // Pair counts: 0 if the upper bit is set, 1 if only the lower
            // bit is set, 2 if the pair is all zero.
            always_comb begin
                comb_s = '0;
                for (int n = 0; n < NN; n++) begin
                    if (tree_in_s[2*n+1]) begin
                        comb_s[n*CW +: CW] = 2'd0;
                    end else if (tree_in_s[2*n]) begin
                        comb_s[n*CW +: CW] = 2'd1;
                    end else begin
                        comb_s[n*CW +: CW] = 2'd2;
                    end
                end
            end
        end else begin : g_merge
            localparam int PW = CW - 1;
            logic [2*NN*PW-1:0] prev_s;
            assign prev_s = g_lvl[k-1].out_s;

            // Merge halves: an all-zero upper half contributes its full span,
            // which is added to the lower count; otherwise the upper count
            // alone is the answer.
            always_comb begin
                comb_s = '0;
                for (int n = 0; n < NN; n++) begin
                    if (prev_s[(2*n+1)*PW + PW - 1]) begin
                        comb_s[n*CW +: CW] = {1'b0, prev_s[(2*n+1)*PW +: PW]}
                                           + {1'b0, prev_s[2*n*PW +: PW]};
                    end else begin
                        comb_s[n*CW +: CW] = {1'b0, prev_s[(2*n+1)*PW +: PW]};
                    end
                end
            end
        end

        if (REG) begin : g_reg
            logic [NN*CW-1:0] lvl_r;

            // Level result register, advancing in step with its stage valid bit.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    lvl_r <= '0;
                end else if (load_s[STG] && in_valid_s[STG]) begin
                    lvl_r <= comb_s;
                end else begin
                    lvl_r <= lvl_r;
                end
            end

            assign out_s = lvl_r;
        end else begin : g_comb
            assign out_s = comb_s;
        end
    end

    assign data_out_tdata  = {g_lvl[L-1].out_s, word_r[NS-1]};
    assign data_out_tvalid = valid_r[NS-1];
    assign data_out_tlast  = last_r[NS-1];

endmodule

// File: tb/tb_piradip_leading_zero_count.sv
// Scoreboard bench for piradip_leading_zero_count. Three instances are used:
// unsigned pipelined (0), signed pipelined (1) and unsigned combinational (2).
// Drivers push hand-computed {count, word} expectations at acceptance time.
// A separate monitor pops and compares whenever an output transfer happens.
module tb_piradip_leading_zero_count;

    typedef struct packed {
        logic [37:0] tdata;
        logic        tlast;
        logic [31:0] acc;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [31:0] in_data   [3];
    logic        in_valid  [3];
    logic        in_last   [3];
    logic        in_ready  [3];
    logic [37:0] out_data  [3];
    logic        out_valid [3];
    logic        out_last  [3];
    logic        out_ready [3];

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    int          checks;
    int          passes;
    logic [31:0] cyc;
    logic        lat_chk [3];
    int          n_acc   [3];
    int          first_stall;
    logic        track;
    logic        stall_prev;
    logic [37:0] stall_data;

    logic [31:0] dir_w [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [5:0]  dir_c [3] = '{6'd0, 6'd31, 6'd32};
    logic [31:0] sgn_w [6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hC000_0000,
                               32'h4000_0000, 32'h0000_0001, 32'hFFFF_8000};
    logic [5:0]  sgn_c [6] = '{6'd31, 6'd31, 6'd1, 6'd0, 6'd30, 6'd16};

    piradip_leading_zero_count #(.DATA_WIDTH(32), .PIPELINE(1), .SIGNED(0)) u_dut_u (
        .clk(clk), .resetn(resetn),
        .data_in_tdata(in_data[0]), .data_in_tvalid(in_valid[0]),
        .data_in_tready(in_ready[0]), .data_in_tlast(in_last[0]),
        .data_out_tdata(out_data[0]), .data_out_tvalid(out_valid[0]),
        .data_out_tready(out_ready[0]), .data_out_tlast(out_last[0])
    );

    piradip_leading_zero_count #(.DATA_WIDTH(32), .PIPELINE(1), .SIGNED(1)) u_dut_s (
        .clk(clk), .resetn(resetn),
        .data_in_tdata(in_data[1]), .data_in_tvalid(in_valid[1]),
        .data_in_tready(in_ready[1]), .data_in_tlast(in_last[1]),
        .data_out_tdata(out_data[1]), .data_out_tvalid(out_valid[1]),
        .data_out_tready(out_ready[1]), .data_out_tlast(out_last[1])
    );

    piradip_leading_zero_count #(.DATA_WIDTH(32), .PIPELINE(0), .SIGNED(0)) u_dut_c (
        .clk(clk), .resetn(resetn),
        .data_in_tdata(in_data[2]), .data_in_tvalid(in_valid[2]),
        .data_in_tready(in_ready[2]), .data_in_tlast(in_last[2]),
        .data_out_tdata(out_data[2]), .data_out_tvalid(out_valid[2]),
        .data_out_tready(out_ready[2]), .data_out_tlast(out_last[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic int lat_of(input int d);
        case (d)
            2:       lat_of = 1;
            default: lat_of = 6;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int d, output exp_t e, output logic have);
        have = 1'b0;
        e    = '0;
        case (d)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
    endtask

    // Offer one word; called on a falling edge, returns on the falling edge
    // after the accepting rising edge.
    task automatic send(input int d, input logic [31:0] w, input logic l, input logic [5:0] c);
        exp_t e;
        int   t;
        logic done;
        done        = 1'b0;
        in_data[d]  = w;
        in_last[d]  = l;
        in_valid[d] = 1'b1;
        for (t = 0; t < 300 && !done; t++) begin
            #1;
            if (in_ready[d]) begin
                e.tdata = {c, w};
                e.tlast = l;
                e.acc   = cyc;
                push(d, e);
                n_acc[d]++;
                done = 1'b1;
            end else if (track && d == 0 && first_stall < 0) begin
                first_stall = n_acc[0];
            end
            @(negedge clk);
        end
        if (!done) check($sformatf("send_timeout[%0d]", d), 64'(t), 64'd0);
    endtask

    task automatic idle(input int d);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 200 && (q0.size() + q1.size() + q2.size()) != 0; t++) @(negedge clk);
        check("drain_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    // Scoreboard monitor: pops on every output handshake; also checks that a
    // stalled output of instance 0 holds valid and data.
    always @(negedge clk) begin
        exp_t e;
        logic have;
        #2;
        for (int d = 0; d < 3; d++) begin
            if (resetn && out_valid[d] && out_ready[d]) begin
                pop(d, e, have);
                check($sformatf("sb_entry[%0d]", d), {63'd0, have}, 64'd1);
                if (have) begin
                    check($sformatf("tdata[%0d]", d), 64'(out_data[d]), 64'(e.tdata));
                    check($sformatf("tlast[%0d]", d), 64'(out_last[d]), 64'(e.tlast));
                    if (lat_chk[d]) begin
                        check($sformatf("latency[%0d]", d), 64'(cyc - e.acc), 64'(lat_of(d)));
                    end
                end
            end
        end
        if (stall_prev && resetn) begin
            check("stall_valid", 64'(out_valid[0]), 64'd1);
            check("stall_data", 64'(out_data[0]), 64'(stall_data));
        end
        stall_prev = resetn && out_valid[0] && !out_ready[0];
        stall_data = out_data[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ones;
        ones        = '1;
        checks      = 0;
        passes      = 0;
        cyc         = 32'd0;
        first_stall = -1;
        track       = 1'b0;
        stall_prev  = 1'b0;
        stall_data  = '0;
        resetn      = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            in_last[d]   = 1'b0;
            out_ready[d] = 1'b1;
            lat_chk[d]   = 1'b1;
            n_acc[d]     = 0;
        end

        // Reset state
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_tvalid[%0d]", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("rst_tdata[%0d]", d), 64'(out_data[d]), 64'd0);
            check($sformatf("rst_tready[%0d]", d), 64'(in_ready[d]), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("tready_at_release", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("tready_after_release[%0d]", d), 64'(in_ready[d]), 64'd1);
        end

        // Unsigned directed words with latency check
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(0, dir_w[i], 1'b0, dir_c[i]);
        idle(0);
        drain();

        // Unsigned sweep, back-to-back
        @(negedge clk);
        for (int i = 0; i <= 32; i++) send(0, ones >> i, i == 32, 6'(i));
        idle(0);
        drain();

        // Signed mode
        @(negedge clk);
        for (int i = 0; i < 6; i++) send(1, sgn_w[i], i == 5, sgn_c[i]);
        idle(1);
        drain();

        // Combinational variant sweep
        @(negedge clk);
        for (int i = 0; i <= 32; i++) send(2, ones >> i, i == 32, 6'(i));
        idle(2);
        drain();

        // Backpressure: sink stalled for 12 cycles while 10 words are offered
        lat_chk[0]  = 1'b0;
        first_stall = -1;
        n_acc[0]    = 0;
        track       = 1'b1;
        @(negedge clk);
        fork
            begin
                out_ready[0] = 1'b0;
                repeat (12) @(negedge clk);
                out_ready[0] = 1'b1;
            end
            begin
                for (int k = 0; k < 10; k++) send(0, 32'h1 << k, k == 9, 6'(31 - k));
                idle(0);
            end
        join
        drain();
        track = 1'b0;
        check("bp_accepted_before_stall", 64'(first_stall), 64'd6);
        check("bp_accepted_total", 64'(n_acc[0]), 64'd10);

        // Reset with four words in flight
        @(negedge clk);
        out_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 32'hA5A5_0000 + 32'(k), 1'b0, 6'd0);
        idle(0);
        repeat (4) @(negedge clk);
        #3;
        check("pre_reset_tvalid", 64'(out_valid[0]), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("reset_tvalid_falls", 64'(out_valid[0]), 64'd0);
        check("reset_tdata_zero", 64'(out_data[0]), 64'd0);
        check("reset_tready_low", 64'(in_ready[0]), 64'd0);
        q0.delete();
        out_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        #5;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        send(0, 32'h0000_00FF, 1'b1, 6'd24);
        idle(0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
